// File: rtl/control_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_hazard_ctrl_pkg
//  Brief    : Shared types and constants for the control-hazard sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package control_hazard_ctrl_pkg;

    // Sequencer states: normal operation, or holding a redirect for fetch.
    typedef enum logic [0:0] {
        S_RUN        = 1'b0,
        S_REDIR_WAIT = 1'b1
    } state_t;

    // Conditional-branch funct3 encodings (BEQ..BGEU).
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // A fetch target is legal only on a 4-byte boundary (no compressed ISA).
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Brief    : Combinational load-use hazard detector (EX load vs ID sources).
//  Revision : 1.0 - initial release
// ============================================================================
module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       hazard
);

    logic w_rd_live;
    logic w_hit_rs1;
    logic w_hit_rs2;

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign w_rd_live = ex_valid & ex_mem_read & (ex_rd != 5'd0);
    assign w_hit_rs1 = id_use_rs1 & (id_rs1 == ex_rd);
    assign w_hit_rs2 = id_use_rs2 & (id_rs2 == ex_rd);
    assign hazard    = w_rd_live & (w_hit_rs1 | w_hit_rs2);

endmodule
`default_nettype wire

// File: rtl/control_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : control_hazard_ctrl
//  Brief    : Control-hazard sequencer: fetch redirect, flush/stall control,
//             load-use bubbles and saturating branch statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module control_hazard_ctrl
    import control_hazard_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_taken,
    input  logic             ex_jump,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             imem_ready,
    output logic             pc_redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_target;
    logic              w_load_target;
    logic              w_redir_req;
    logic              w_aligned;
    logic              w_load_use;
    logic              w_br_evt;
    logic              w_tk_evt;

    assign w_redir_req = ex_valid & ((ex_branch & ex_taken) | ex_jump);
    assign w_aligned   = is_word_aligned(ex_target[1:0]);

    // Branch events only count while EX holds real instructions (RUN).
    assign w_br_evt = (r_state == S_RUN) & ex_valid & ex_branch;
    assign w_tk_evt = w_br_evt & ex_taken;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .hazard      (w_load_use)
    );

    // State register and held redirect target; reset drops any pending target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_target <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_target) begin
                r_target <= ex_target;
            end
        end
    end

    // Next state and pipeline control; flushes and stalls are mutually exclusive.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_target = 1'b0;
        pc_redirect   = 1'b0;
        redirect_pc   = r_target;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        misalign_exc  = 1'b0;
        if (reset) begin
            redirect_pc = '0;
        end else if (r_state == S_REDIR_WAIT) begin
            // Keep squashing whatever fetch produces until the redirect lands.
            pc_redirect = imem_ready;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (imem_ready) begin
                w_state_nxt = S_RUN;
            end
        end else if (w_redir_req) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (!w_aligned) begin
                misalign_exc = 1'b1;
            end else if (imem_ready) begin
                pc_redirect = 1'b1;
                redirect_pc = ex_target;
            end else begin
                w_load_target = 1'b1;
                w_state_nxt   = S_REDIR_WAIT;
            end
        end else if (w_load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // Saturating statistics counters: stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            if (w_br_evt && (branch_cnt != c_cnt_max)) begin
                branch_cnt <= branch_cnt + c_cnt_one;
            end
            if (w_tk_evt && (taken_cnt != c_cnt_max)) begin
                taken_cnt <= taken_cnt + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_hazard_ctrl
//  Brief    : Self-checking bench for control_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0, ex_branch = 1'b0, ex_taken = 1'b0, ex_jump = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, imem_ready = 1'b0;

    logic        pc_redirect, pc_stall, if_id_stall, if_id_flush, id_ex_flush, misalign_exc;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, taken_cnt;

    logic        s_pc_redirect, s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_flush, s_misalign_exc;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_branch_cnt, s_taken_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    control_hazard_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_taken(ex_taken), .ex_jump(ex_jump), .ex_target(ex_target),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .imem_ready(imem_ready),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .misalign_exc(misalign_exc), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    // Narrow-counter instance on the same stimulus, so saturation is reachable quickly.
    control_hazard_ctrl #(.XLEN(32), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_taken(ex_taken), .ex_jump(ex_jump), .ex_target(ex_target),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .imem_ready(imem_ready),
        .pc_redirect(s_pc_redirect), .redirect_pc(s_redirect_pc), .pc_stall(s_pc_stall),
        .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .misalign_exc(s_misalign_exc), .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pending = 1'b0;   // a redirect is owed to fetch
    logic [31:0] m_target  = '0;
    int          m_b = 0, m_t = 0, m_b4 = 0, m_t4 = 0;

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pending = 1'b0; m_target = '0;
            m_b = 0; m_t = 0; m_b4 = 0; m_t4 = 0;
        end else if (m_pending) begin
            if (imem_ready) m_pending = 1'b0;
        end else begin
            if (ex_valid && ex_branch) begin
                m_b  = sat_inc(m_b, 65535);
                m_b4 = sat_inc(m_b4, 15);
                if (ex_taken) begin
                    m_t  = sat_inc(m_t, 65535);
                    m_t4 = sat_inc(m_t4, 15);
                end
            end
            if (ex_valid && ((ex_branch && ex_taken) || ex_jump) &&
                ex_target[1:0] == 2'b00 && !imem_ready) begin
                m_pending = 1'b1;
                m_target  = ex_target;
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit e_redir, e_stall, e_iflush, e_eflush, e_mis, req, lu;
            logic [31:0] e_pc;
            e_redir = 0; e_stall = 0; e_iflush = 0; e_eflush = 0; e_mis = 0; e_pc = '0;
            req = ex_valid && ((ex_branch && ex_taken) || ex_jump);
            lu  = ex_valid && ex_mem_read && ex_rd != 0 &&
                  ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            if (reset) begin
                e_pc = '0;
            end else if (m_pending) begin
                e_redir = imem_ready; e_pc = m_target; e_iflush = 1; e_eflush = 1;
            end else if (req) begin
                e_iflush = 1; e_eflush = 1;
                if (ex_target[1:0] != 0) e_mis = 1;
                else if (imem_ready) begin e_redir = 1; e_pc = ex_target; end
            end else if (lu) begin
                e_stall = 1; e_eflush = 1;
            end
            chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, e_redir});
            chk("pc_stall", {31'd0, pc_stall}, {31'd0, e_stall});
            chk("if_id_stall", {31'd0, if_id_stall}, {31'd0, e_stall});
            chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_iflush});
            chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e_eflush});
            chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, e_mis});
            if (reset || e_redir) chk("redirect_pc", redirect_pc, e_pc);
            chk("branch_cnt", {16'd0, branch_cnt}, m_b);
            chk("taken_cnt", {16'd0, taken_cnt}, m_t);
            chk("s_pc_redirect", {31'd0, s_pc_redirect}, {31'd0, e_redir});
            chk("s_if_id_flush", {31'd0, s_if_id_flush}, {31'd0, e_iflush});
            chk("s_branch_cnt", {28'd0, s_branch_cnt}, m_b4);
            chk("s_taken_cnt", {28'd0, s_taken_cnt}, m_t4);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic vec(input logic v, input logic br, input logic tk, input logic j,
                       input logic [31:0] tgt, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rdy);
        ex_valid = v; ex_branch = br; ex_taken = tk; ex_jump = j; ex_target = tgt;
        ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; imem_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        vec(0, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, rdy);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        @(negedge clk);
        chk("rst_pc_redirect", {31'd0, pc_redirect}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        next_cycle();

        // 1: BEQ taken, fetch ready -> immediate redirect
        vec(1, 1, 1, 0, 32'h100, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        @(negedge clk);
        chk("t1_redirect", {31'd0, pc_redirect}, 32'd1);
        chk("t1_pc", redirect_pc, 32'h100);
        chk("t1_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        next_cycle(); idle(1);
        @(negedge clk);
        chk("t1_cnt", {branch_cnt, taken_cnt}, {16'd1, 16'd1});
        next_cycle();

        // 2: JAL while fetch busy for three cycles; a branch during the wait is ignored
        vec(1, 0, 0, 1, 32'h200, 0, 5'd1, 5'd0, 5'd0, 0, 0, 0);
        @(negedge clk); chk("t2_c1", {30'd0, pc_redirect, if_id_flush}, 32'd1);
        next_cycle(); vec(1, 1, 1, 0, 32'h300, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        @(negedge clk); chk("t2_c2", {30'd0, pc_redirect, id_ex_flush}, 32'd1);
        next_cycle(); idle(0);
        @(negedge clk); chk("t2_c3", {30'd0, pc_redirect, if_id_flush}, 32'd1);
        next_cycle(); idle(1);
        @(negedge clk);
        chk("t2_c4", {30'd0, pc_redirect, if_id_flush}, 32'd3);
        chk("t2_pc", redirect_pc, 32'h200);
        next_cycle(); idle(1);
        @(negedge clk);
        chk("t2_after", {30'd0, pc_redirect, if_id_flush}, 32'd0);
        chk("t2_cnt", {branch_cnt, taken_cnt}, {16'd1, 16'd1});
        next_cycle();

        // 3: load-use on rs1, then x0 destination, then a match on an unused rs
        vec(1, 0, 0, 0, 32'h0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1);
        @(negedge clk);
        chk("t3_stall", {29'd0, pc_stall, if_id_stall, id_ex_flush}, 32'd7);
        chk("t3_noflush", {31'd0, if_id_flush}, 32'd0);
        next_cycle(); vec(1, 0, 0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 1);
        @(negedge clk); chk("t3_x0", {31'd0, pc_stall}, 32'd0);
        next_cycle(); vec(1, 0, 0, 0, 32'h0, 1, 5'd7, 5'd7, 5'd7, 0, 0, 1);
        @(negedge clk); chk("t3_unused", {31'd0, pc_stall}, 32'd0);
        next_cycle(); vec(1, 0, 0, 0, 32'h0, 1, 5'd9, 5'd1, 5'd9, 0, 1, 1);
        @(negedge clk); chk("t3_rs2", {31'd0, if_id_stall}, 32'd1);
        next_cycle();

        // 4: taken BNE with simultaneous load-use match -> redirect wins
        vec(1, 1, 1, 0, 32'h180, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1);
        @(negedge clk);
        chk("t4_redirect", {31'd0, pc_redirect}, 32'd1);
        chk("t4_nostall", {30'd0, pc_stall, if_id_stall}, 32'd0);
        chk("t4_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        next_cycle(); vec(1, 1, 0, 0, 32'h1c0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        @(negedge clk); chk("t4_nt", {30'd0, pc_redirect, if_id_flush}, 32'd0);
        next_cycle();

        // 5: misaligned target, then saturation on the narrow counters
        vec(1, 1, 1, 0, 32'h102, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        @(negedge clk);
        chk("t5_mis", {31'd0, misalign_exc}, 32'd1);
        chk("t5_noredir", {31'd0, pc_redirect}, 32'd0);
        next_cycle(); idle(1);
        @(negedge clk);
        chk("t5_pulse", {31'd0, misalign_exc}, 32'd0);
        chk("t5_cnt", {branch_cnt, taken_cnt}, {16'd4, 16'd3});
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            vec(1, 1, 1, 0, 32'h1000 + 32'(i * 4), 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
            next_cycle();
        end
        idle(1);
        @(negedge clk);
        chk("t5_sat", {24'd0, s_branch_cnt, s_taken_cnt}, 32'hFF);
        chk("t5_wide", {branch_cnt, taken_cnt}, {16'd24, 16'd23});
        next_cycle(); vec(1, 1, 1, 0, 32'h102, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        next_cycle(); idle(1);
        @(negedge clk);
        chk("t5_hold", {24'd0, s_branch_cnt, s_taken_cnt}, 32'hFF);
        chk("t5_wide2", {branch_cnt, taken_cnt}, {16'd25, 16'd24});
        next_cycle();

        // 6: async reset while a redirect is pending
        vec(1, 0, 0, 1, 32'h400, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        next_cycle(); idle(0);
        #2;
        chk("t6_wait", {31'd0, if_id_flush}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_out", {28'd0, pc_redirect, if_id_flush, id_ex_flush, misalign_exc}, 32'd0);
        chk("t6_rst_cnt", {branch_cnt, taken_cnt}, 32'd0);
        next_cycle(); reset = 1'b0; idle(1);
        @(negedge clk);
        chk("t6_no_issue", {30'd0, pc_redirect, if_id_flush}, 32'd0);
        next_cycle(); next_cycle();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
